clk_down_counter: RTL and testbench

//   Loadable, enable-gated down counter/timer. It is the counterpart to clk_up_counter:
//   it counts down from a loaded value and flags terminal count.

---
 rtl/clk_down_counter.sv | 101 ++++++++++
 tb/tb_clk_down_counter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/clk_down_counter.sv
// clk_down_counter: loadable, enable-gated down counter / interval timer.
//   One-shot mode (AUTO_RELOAD=0) stops at zero and holds done until load/clr.
//   Periodic mode (AUTO_RELOAD=1) reloads the stored value on terminal count.
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous active-low reset
//   clr      - synchronous clear of count/state (stored reload value kept)
//   enable   - count-down qualifier while running
//   load     - capture load_val and start counting
//   load_val - start / reload value
//   out      - current count (registered)
//   tc       - terminal-count pulse, one cycle wide (registered)
//   busy     - high while running (registered)
//   done     - high once a one-shot run has expired (registered, sticky)
module clk_down_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state / next-output logic; priority clr > load > enable.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (clr) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (load) begin
      reload_d = load_val;
      count_d  = load_val;
      state_d  = (load_val != '0) ? ST_RUN : ST_IDLE;
    end else if (state_q == ST_RUN && enable) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        // Terminal count; a zero count can never be decremented, so no wrap.
        tc_d = 1'b1;
        if (AUTO_RELOAD) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = ST_DONE;
        end
      end
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign out  = count_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_clk_down_counter.sv
module tb_clk_down_counter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset, clr, enable, load;
  logic [W-1:0] load_val;

  logic [W-1:0] out_os, out_pr;
  logic         tc_os, tc_pr, busy_os, busy_pr, done_os, done_pr;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Behavioural model: index 0 = one-shot, 1 = periodic.
  int m_out[2];
  int m_tc[2];
  int m_mode[2];   // 0 idle, 1 counting, 2 expired
  int m_rel[2];

  always #5 clk = ~clk;

  clk_down_counter #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u_os (
    .clk(clk), .reset(reset), .clr(clr), .enable(enable), .load(load),
    .load_val(load_val), .out(out_os), .tc(tc_os), .busy(busy_os), .done(done_os)
  );

  clk_down_counter #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u_pr (
    .clk(clk), .reset(reset), .clr(clr), .enable(enable), .load(load),
    .load_val(load_val), .out(out_pr), .tc(tc_pr), .busy(busy_pr), .done(done_pr)
  );

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model advances on each rising edge from the sampled inputs.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_out[i] = 0; m_tc[i] = 0; m_mode[i] = 0; m_rel[i] = 0;
      end else if (clr) begin
        m_out[i] = 0; m_tc[i] = 0; m_mode[i] = 0;
      end else if (load) begin
        m_rel[i] = int'(load_val);
        m_out[i] = int'(load_val);
        m_tc[i]  = 0;
        m_mode[i] = (load_val == 0) ? 0 : 1;
      end else if (m_mode[i] == 1 && enable) begin
        m_out[i] = m_out[i] - 1;
        m_tc[i]  = (m_out[i] == 0) ? 1 : 0;
        if (m_out[i] == 0) begin
          if (i == 1) m_out[i] = m_rel[i];
          else        m_mode[i] = 2;
        end
      end else begin
        m_tc[i] = 0;
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("os.out",  int'(out_os),  m_out[0]);
      cmp("os.tc",   int'(tc_os),   m_tc[0]);
      cmp("os.busy", int'(busy_os), int'(m_mode[0] == 1));
      cmp("os.done", int'(done_os), int'(m_mode[0] == 2));
      cmp("pr.out",  int'(out_pr),  m_out[1]);
      cmp("pr.tc",   int'(tc_pr),   m_tc[1]);
      cmp("pr.busy", int'(busy_pr), int'(m_mode[1] == 1));
      cmp("pr.done", int'(done_pr), int'(m_mode[1] == 2));
    end
  end

  // Advance one clock; returns just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic c, input logic e,
                       input logic l, input logic [W-1:0] v);
    reset = r; clr = c; enable = e; load = l; load_val = v;
  endtask

  initial begin
    int pulses;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd5);

    // Reset dominates load and enable.
    step(); step();
    chk_on = 1'b1;
    cmp("rst.out", int'(out_os), 0);
    cmp("rst.tc_busy_done", int'({tc_os, busy_os, done_os}), 0);
    cmp("rst.pr_out", int'(out_pr), 0);

    // One-shot load 3: 3,2,1,0 with tc on the zero cycle.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd3);
    step();
    cmp("os3.load", int'(out_os), 3);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    step(); cmp("os3.c2", int'(out_os), 2); cmp("os3.tc2", int'(tc_os), 0);
    step(); cmp("os3.c1", int'(out_os), 1);
    step(); cmp("os3.c0", int'(out_os), 0); cmp("os3.tc0", int'(tc_os), 1);
    cmp("pr3.reload", int'(out_pr), 3); cmp("pr3.tc", int'(tc_pr), 1);
    for (int k = 0; k < 5; k++) begin
      step();
      cmp("os3.hold", int'(out_os), 0);
      cmp("os3.done", int'({done_os, busy_os, tc_os}), 3'b100);
    end

    // Periodic load 4, 12 enabled cycles: 3 tc pulses, never done.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd4);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      pulses += int'(tc_pr);
      cmp("pr4.out", int'(out_pr), 3 - (k % 4) + ((k % 4 == 3) ? 4 : 0));
      cmp("pr4.done", int'(done_pr), 0);
    end
    cmp("pr4.pulses", pulses, 3);

    // Enable toggling: 5,4,4,3,3.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd5);
    step(); cmp("tog.5", int'(out_os), 5);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0); step(); cmp("tog.4a", int'(out_os), 4);
    enable = 1'b0; step(); cmp("tog.4b", int'(out_os), 4);
    enable = 1'b1; step(); cmp("tog.3a", int'(out_os), 3);
    enable = 1'b0; step(); cmp("tog.3b", int'(out_os), 3);
    cmp("tog.tc", int'(tc_os), 0);

    // Load on the terminal cycle wins; then clr mid-run.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd2); step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0); step();
    cmp("ldt.c1", int'(out_os), 1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd7); step();
    cmp("ldt.out", int'(out_os), 7); cmp("ldt.tc", int'(tc_os), 0);
    cmp("ldt.busy", int'(busy_os), 1);
    load = 1'b0;
    step(); step(); step();
    cmp("ldt.c4", int'(out_os), 4);
    clr = 1'b1; step();
    cmp("clr.out", int'(out_os), 0); cmp("clr.busy", int'(busy_os), 0);
    clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      cmp("clr.idle", int'(out_os), 0);
    end

    // Load zero: idle, no tc.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd0); step();
    cmp("ld0", int'({out_os, tc_os, busy_os, done_os}), 0);

    // Full-range one-shot: 255 enabled cycles to zero, no wrap.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF); step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 255; k++) step();
    cmp("ff.zero", int'(out_os), 0); cmp("ff.tc", int'(tc_os), 1);
    step();
    cmp("ff.nowrap", int'(out_os), 0); cmp("ff.done", int'(done_os), 1);

    // Randomized traffic checked per cycle against the model.
    for (int k = 0; k < 3000; k++) begin
      reset    = ($urandom_range(0, 99) >= 2);
      clr      = ($urandom_range(0, 99) < 3);
      load     = ($urandom_range(0, 99) < 8);
      enable   = ($urandom_range(0, 99) < 75);
      load_val = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      step();
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
